// File: rtl/rom_pkg.sv
// rom_pkg: shared types, widths and ROM content function for the banked ROM controller
package rom_pkg;
  localparam int TAG_W = 8;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, READ, WAITS, RESP} state_t;
  function automatic logic [31:0] rom_word(input logic [31:0] seed, input logic [31:0] idx);
    return seed + idx * 32'd3;
  endfunction
endpackage

// File: rtl/rom_bank_ctrl_if.sv
// rom_bank_ctrl_if: read request/response bus between a requester and the ROM controller
interface rom_bank_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  modport master(output req, addr, input ready, rvalid, rdata, err);
  modport slave(input req, addr, output ready, rvalid, rdata, err);
endinterface

// File: rtl/rom_bank.sv
// rom_bank: synchronous-read ROM whose contents are generated from a per-bank init seed
module rom_bank import rom_pkg::*; #(
  parameter int          IDX_W  = 8,
  parameter int          DATA_W = 8,
  parameter logic [31:0] INIT   = 32'h0
) (
  input  logic              clk,
  input  logic              en,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] dout
);
  // one-cycle registered read, output holds while not enabled
  always_ff @(posedge clk)
    if (en) dout <= DATA_W'(rom_word(INIT, 32'(idx)));
endmodule

// File: rtl/rom_bank_ctrl.sv
// rom_bank_ctrl: tag-decoded multi-bank ROM read controller with fixed-latency response
module rom_bank_ctrl import rom_pkg::*; #(
  parameter int                         NUM_BANKS = 2,
  parameter int                         IDX_W     = 8,
  parameter int                         DATA_W    = 8,
  parameter int                         WAIT      = 0,
  parameter logic [NUM_BANKS*TAG_W-1:0] BANK_TAGS = {8'h21, 8'h20},
  parameter logic [NUM_BANKS*32-1:0]    BANK_INIT = {32'h50, 32'hA0}
) (
  input logic             clk,
  input logic             rst,
  rom_bank_ctrl_if.slave  bus
);
  localparam int SEL_W = NUM_BANKS > 1 ? $clog2(NUM_BANKS) : 1;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEL_W-1:0]   sel, sel_q;
  logic               hit, bad, en;
  logic               ready_q, rvalid_q, err_q;
  logic [31:0]        rdata_q, resp_data;
  logic [DATA_W-1:0]  bank_dout [NUM_BANKS];
  logic [DATA_W-1:0]  sel_dout;
  // lowest-index bank whose tag matches the request address wins
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_BANKS - 1; i >= 0; i--)
      if (bus.addr[31:24] == BANK_TAGS[i*TAG_W +: TAG_W]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
  end
  assign bad       = !hit || bus.addr[1:0] != 2'b00;
  assign en        = state == IDLE && bus.req && !rst;
  assign sel_dout  = bank_dout[sel_q];
  assign resp_data = 32'(sel_dout);
  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    rom_bank #(.IDX_W(IDX_W), .DATA_W(DATA_W), .INIT(BANK_INIT[g*32 +: 32])) u_bank (
      .clk (clk),
      .en  (en),
      .idx (bus.addr[IDX_W+1:2]),
      .dout(bank_dout[g])
    );
  end
  // request/response sequencing with registered handshake and data outputs
  always_ff @(posedge clk)
    if (rst) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt      <= '0;
      sel_q    <= '0;
    end else begin
      case (state)
        IDLE:
          if (bus.req) begin
            ready_q <= 1'b0;
            sel_q   <= sel;
            if (bad) begin
              state    <= RESP;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= '0;
            end else state <= READ;
          end
        READ, WAITS:
          if (state == READ && WAIT != 0) begin
            state <= WAITS;
            cnt   <= CNT_W'(WAIT - 1);
          end else if (state == WAITS && cnt != 0) cnt <= cnt - 1'b1;
          else begin
            state    <= RESP;
            rvalid_q <= 1'b1;
            err_q    <= 1'b0;
            rdata_q  <= resp_data;
          end
        RESP: begin
          state    <= IDLE;
          rvalid_q <= 1'b0;
          ready_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_rom_bank_ctrl.sv
// tb_rom_bank_ctrl: directed checks of latency, errors, back-to-back, reset and duplicate tags
module tb_rom_bank_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_v    [3];
  logic [31:0] addr_v   [3];
  logic        ready_v  [3];
  logic        rvalid_v [3];
  logic        err_v    [3];
  logic [31:0] rdata_v  [3];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  rom_bank_ctrl_if b0();
  rom_bank_ctrl_if b1();
  rom_bank_ctrl_if b2();

  assign b0.req = req_v[0];
  assign b0.addr = addr_v[0];
  assign ready_v[0] = b0.ready;
  assign rvalid_v[0] = b0.rvalid;
  assign err_v[0] = b0.err;
  assign rdata_v[0] = b0.rdata;
  assign b1.req = req_v[1];
  assign b1.addr = addr_v[1];
  assign ready_v[1] = b1.ready;
  assign rvalid_v[1] = b1.rvalid;
  assign err_v[1] = b1.err;
  assign rdata_v[1] = b1.rdata;
  assign b2.req = req_v[2];
  assign b2.addr = addr_v[2];
  assign ready_v[2] = b2.ready;
  assign rvalid_v[2] = b2.rvalid;
  assign err_v[2] = b2.err;
  assign rdata_v[2] = b2.rdata;

  rom_bank_ctrl u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  rom_bank_ctrl #(.WAIT(3)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  rom_bank_ctrl #(.BANK_TAGS(16'h2020)) u_dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input int d, input logic [31:0] a, input int lat, input logic e, input logic [31:0] dat);
    int   k;
    logic rdy_seen;
    string t;
    t = $sformatf("d%0d@%h", d, a);
    check({t, " ready_idle"}, 32'(ready_v[d]), 32'd1);
    req_v[d]  = 1'b1;
    addr_v[d] = a;
    @(negedge clk);
    req_v[d] = 1'b0;
    k = 1;
    rdy_seen = 1'b0;
    while (!rvalid_v[d] && k <= 20) begin
      rdy_seen |= ready_v[d];
      @(negedge clk);
      k++;
    end
    check({t, " latency"}, 32'(k), 32'(lat));
    check({t, " ready_busy"}, 32'(rdy_seen), 32'd0);
    check({t, " err"}, 32'(err_v[d]), 32'(e));
    check({t, " rdata"}, rdata_v[d], dat);
    @(negedge clk);
    check({t, " one_shot"}, 32'(rvalid_v[d]), 32'd0);
    check({t, " rdata_hold"}, rdata_v[d], dat);
    check({t, " err_hold"}, 32'(err_v[d]), 32'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, nv, last;
    for (int i = 0; i < 3; i++) begin
      req_v[i]  = 1'b0;
      addr_v[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset ready", 32'(ready_v[0]), 32'd1);
    check("reset rvalid", 32'(rvalid_v[0]), 32'd0);
    check("reset err", 32'(err_v[0]), 32'd0);
    check("reset rdata", rdata_v[0], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    xact(0, 32'h2000_0010, 2, 1'b0, 32'h0000_00AC);
    xact(1, 32'h2100_0004, 5, 1'b0, 32'h0000_0053);
    xact(0, 32'h3000_0000, 1, 1'b1, 32'h0000_0000);
    xact(0, 32'h2000_0002, 1, 1'b1, 32'h0000_0000);
    xact(0, 32'h21AB_CFF8, 2, 1'b0, 32'h0000_004A);
    xact(2, 32'h2000_0008, 2, 1'b0, 32'h0000_00A6);
    acc  = 0;
    nv   = 0;
    last = 0;
    req_v[0]  = 1'b1;
    addr_v[0] = 32'h2000_0004;
    for (int c = 0; c < 14; c++) begin
      if (c == 10) req_v[0] = 1'b0;
      if (rvalid_v[0]) begin
        nv++;
        check("b2b rdata", rdata_v[0], 32'h0000_00A3);
      end
      if (req_v[0] && ready_v[0]) begin
        if (acc > 0) check("b2b gap", 32'(c - last), 32'd3);
        acc++;
        last = c;
      end
      @(negedge clk);
    end
    check("b2b accepts", 32'(acc), 32'd4);
    check("b2b responses", 32'(nv), 32'd4);
    req_v[1]  = 1'b1;
    addr_v[1] = 32'h2100_0004;
    @(negedge clk);
    req_v[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst ready", 32'(ready_v[1]), 32'd1);
    check("midrst rvalid", 32'(rvalid_v[1]), 32'd0);
    check("midrst err", 32'(err_v[1]), 32'd0);
    check("midrst rdata", rdata_v[1], 32'd0);
    rst = 1'b0;
    nv = 0;
    repeat (8) begin
      nv += int'(rvalid_v[1]);
      @(negedge clk);
    end
    check("midrst no rvalid", 32'(nv), 32'd0);
    xact(1, 32'h2100_0008, 5, 1'b0, 32'h0000_0056);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
